// File: rtl/equeue_int.sv
// Integer issue queue: age-ordered reservation station that snoops the CDB for pending
// operands and presents the oldest fully-ready entry to the integer issue unit.
module equeue_int #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  dispatch_opcode,
    input  logic        dispatch_en,
    output logic        dispatch_ready,
    input  logic [5:0]  dispatch_rdtag,
    input  logic [5:0]  dispatch_rstag,
    input  logic [5:0]  dispatch_rttag,
    input  logic [31:0] dispatch_rsdata,
    input  logic [31:0] dispatch_rtdata,
    input  logic        dispatch_rsvalid,
    input  logic        dispatch_rtvalid,
    input  logic [5:0]  cdb_tag,
    input  logic        cdb_valid,
    input  logic [31:0] cdb_data,
    output logic [3:0]  issueint_opcode,
    output logic [5:0]  issueint_rdtag,
    output logic [31:0] issueint_rsdata,
    output logic [31:0] issueint_rtdata,
    output logic        issueint_ready,
    input  logic        issueint_done
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [5:0]  rdtag;
        logic [5:0]  rstag;
        logic [5:0]  rttag;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic        rsvalid;
        logic        rtvalid;
    } entry_t;

    entry_t      q   [DEPTH];
    entry_t      nxt [DEPTH];
    entry_t      src [DEPTH+1];
    logic        sel_found;
    int unsigned sel_idx;
    logic        do_issue;
    logic        do_disp;
    logic        placed;

    always_comb begin : free_slot
        dispatch_ready = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!q[i].valid) dispatch_ready = 1'b1;
        end
    end

    always_comb begin : select
        sel_found       = 1'b0;
        sel_idx         = 0;
        issueint_opcode = '0;
        issueint_rdtag  = '0;
        issueint_rsdata = '0;
        issueint_rtdata = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && q[i].valid && q[i].rsvalid && q[i].rtvalid) begin
                sel_found       = 1'b1;
                sel_idx         = i;
                issueint_opcode = q[i].opcode;
                issueint_rdtag  = q[i].rdtag;
                issueint_rsdata = q[i].rsdata;
                issueint_rtdata = q[i].rtdata;
            end
        end
    end

    assign issueint_ready = sel_found;

    // Each slot first takes its compacted source, then snoops the CDB on the moved
    // contents, and finally the lowest slot still empty receives the dispatch.
    always_comb begin : next_state
        do_issue = sel_found && issueint_done;
        do_disp  = dispatch_en && dispatch_ready;
        placed   = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) src[i] = q[i];
        src[DEPTH] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            nxt[i] = (do_issue && i >= sel_idx) ? src[i+1] : src[i];
            if (nxt[i].valid && cdb_valid) begin
                if (!nxt[i].rsvalid && nxt[i].rstag == cdb_tag) begin
                    nxt[i].rsdata  = cdb_data;
                    nxt[i].rsvalid = 1'b1;
                end
                if (!nxt[i].rtvalid && nxt[i].rttag == cdb_tag) begin
                    nxt[i].rtdata  = cdb_data;
                    nxt[i].rtvalid = 1'b1;
                end
            end
            if (do_disp && !placed && !nxt[i].valid) begin
                placed         = 1'b1;
                nxt[i].valid   = 1'b1;
                nxt[i].opcode  = dispatch_opcode;
                nxt[i].rdtag   = dispatch_rdtag;
                nxt[i].rstag   = dispatch_rstag;
                nxt[i].rttag   = dispatch_rttag;
                nxt[i].rsvalid = dispatch_rsvalid ||
                                 (cdb_valid && cdb_tag == dispatch_rstag);
                nxt[i].rtvalid = dispatch_rtvalid ||
                                 (cdb_valid && cdb_tag == dispatch_rttag);
                nxt[i].rsdata  = (!dispatch_rsvalid && cdb_valid && cdb_tag == dispatch_rstag)
                                 ? cdb_data : dispatch_rsdata;
                nxt[i].rtdata  = (!dispatch_rtvalid && cdb_valid && cdb_tag == dispatch_rttag)
                                 ? cdb_data : dispatch_rtdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) q[i] <= nxt[i];
        end
    end

endmodule

// File: tb/tb_equeue_int.sv
// Directed bench for equeue_int: vector table for dispatch/issue flow plus hand-written
// wakeup, forwarding, compaction and reset sequences.
module tb_equeue_int;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  dispatch_opcode;
    logic        dispatch_en;
    logic        dispatch_ready;
    logic [5:0]  dispatch_rdtag;
    logic [5:0]  dispatch_rstag;
    logic [5:0]  dispatch_rttag;
    logic [31:0] dispatch_rsdata;
    logic [31:0] dispatch_rtdata;
    logic        dispatch_rsvalid;
    logic        dispatch_rtvalid;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [3:0]  issueint_opcode;
    logic [5:0]  issueint_rdtag;
    logic [31:0] issueint_rsdata;
    logic [31:0] issueint_rtdata;
    logic        issueint_ready;
    logic        issueint_done;

    int total = 0;
    int bad   = 0;

    equeue_int #(.DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_opcode  (dispatch_opcode),
        .dispatch_en      (dispatch_en),
        .dispatch_ready   (dispatch_ready),
        .dispatch_rdtag   (dispatch_rdtag),
        .dispatch_rstag   (dispatch_rstag),
        .dispatch_rttag   (dispatch_rttag),
        .dispatch_rsdata  (dispatch_rsdata),
        .dispatch_rtdata  (dispatch_rtdata),
        .dispatch_rsvalid (dispatch_rsvalid),
        .dispatch_rtvalid (dispatch_rtvalid),
        .cdb_tag          (cdb_tag),
        .cdb_valid        (cdb_valid),
        .cdb_data         (cdb_data),
        .issueint_opcode  (issueint_opcode),
        .issueint_rdtag   (issueint_rdtag),
        .issueint_rsdata  (issueint_rsdata),
        .issueint_rtdata  (issueint_rtdata),
        .issueint_ready   (issueint_ready),
        .issueint_done    (issueint_done)
    );

    always #5 clk = ~clk;

    // Expected values describe the queue state seen before this row's clock edge.
    typedef struct {
        logic        rst;
        logic        en;
        logic        done;
        logic [31:0] val;
        logic        edr;
        logic        eir;
        logic [31:0] ev;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en, input logic done, input int val,
                                input logic edr, input logic eir, input int ev);
        vec_t v;
        v.rst  = rst;
        v.en   = en;
        v.done = done;
        v.val  = 32'(val);
        v.edr  = edr;
        v.eir  = eir;
        v.ev   = 32'(ev);
        return v;
    endfunction

    task automatic drive(input logic en, input logic done, input logic [3:0] op,
                         input logic [5:0] rd, input logic [5:0] rst, input logic rsv,
                         input logic [31:0] rsd, input logic [5:0] rtt, input logic rtv,
                         input logic [31:0] rtd, input logic cv, input logic [5:0] ct,
                         input logic [31:0] cd);
        dispatch_en      = en;
        issueint_done    = done;
        dispatch_opcode  = op;
        dispatch_rdtag   = rd;
        dispatch_rstag   = rst;
        dispatch_rsvalid = rsv;
        dispatch_rsdata  = rsd;
        dispatch_rttag   = rtt;
        dispatch_rtvalid = rtv;
        dispatch_rtdata  = rtd;
        cdb_valid        = cv;
        cdb_tag          = ct;
        cdb_data         = cd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0, 6'd0, 32'd0);
    endtask

    task automatic check(input string nm, input logic edr, input logic eir, input logic [3:0] eop,
                         input logic [5:0] erd, input logic [31:0] ers, input logic [31:0] ert);
        #4;
        total++;
        if (dispatch_ready !== edr) begin
            bad++;
            $display("FAIL %s dispatch_ready got %0b want %0b", nm, dispatch_ready, edr);
        end
        total++;
        if (issueint_ready !== eir) begin
            bad++;
            $display("FAIL %s issueint_ready got %0b want %0b", nm, issueint_ready, eir);
        end
        total++;
        if ({issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata} !== {eop, erd, ers, ert}) begin
            bad++;
            $display("FAIL %s issue op/rd/rs/rt got %h/%h/%h/%h want %h/%h/%h/%h", nm,
                     issueint_opcode, issueint_rdtag, issueint_rsdata, issueint_rtdata,
                     eop, erd, ers, ert);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Plan 1: idle with busy-looking inputs
        for (int v = 5; v <= 14; v++) vecs.push_back(mk(1, 0, 0, v, 1, 0, 0));
        // Plan 2: fill past capacity, then drain (first drain row also tries a dropped dispatch)
        vecs.push_back(mk(1, 1, 0, 5, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 6, 1, 1, 5));
        vecs.push_back(mk(1, 1, 0, 7, 1, 1, 5));
        vecs.push_back(mk(1, 1, 0, 8, 1, 1, 5));
        for (int v = 9; v <= 14; v++) vecs.push_back(mk(1, 1, 0, v, 0, 1, 5));
        vecs.push_back(mk(1, 1, 1, 20, 0, 1, 5));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 6));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 7));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 8));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        // Plan 3: streaming dispatch + issue
        vecs.push_back(mk(1, 1, 1, 5, 1, 0, 0));
        for (int v = 6; v <= 14; v++) vecs.push_back(mk(1, 1, 1, v, 1, 1, v - 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 14));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        // Plan 4: single dispatch then issue
        vecs.push_back(mk(1, 1, 1, 5, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 5));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0));
        // Reset mid-operation with dispatch and done asserted in the reset cycle
        vecs.push_back(mk(1, 1, 0, 7, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 8, 1, 1, 7));
        vecs.push_back(mk(0, 1, 1, 9, 1, 1, 7));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0));

        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_state", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            drive(vecs[i].en, vecs[i].done, vecs[i].val[3:0], vecs[i].val[5:0], vecs[i].val[5:0],
                  1'b1, vecs[i].val, vecs[i].val[5:0], 1'b1, vecs[i].val, 1'b0, 6'd0, 32'd0);
            check($sformatf("vec%0d", i), vecs[i].edr, vecs[i].eir, vecs[i].ev[3:0],
                  vecs[i].ev[5:0], vecs[i].ev, vecs[i].ev);
            next_cycle();
        end
        reset = 1'b1;

        // Plan 5: CDB wakeup of a pending rs operand
        drive(1, 0, 4'd3, 6'd3, 6'd9, 0, 32'd0, 6'd0, 1, 32'd7, 0, 6'd0, 32'd0);
        check("p5_empty", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd10, 32'h1234);
        check("p5_pending", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd9, 32'hDEADBEEF);
        check("p5_nomatch", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 1, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 0, 6'd0, 32'd0);
        check("p5_woken", 1, 1, 4'd3, 6'd3, 32'hDEADBEEF, 32'd7);
        next_cycle();
        // Same-cycle dispatch forwarding on rs; rt woken a cycle later
        drive(1, 0, 4'd6, 6'd6, 6'd12, 0, 32'd0, 6'd13, 0, 32'd0, 1, 6'd12, 32'h1111);
        check("p5_issued", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd13, 32'h2222);
        check("p5_rt_pending", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 1, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 0, 6'd0, 32'd0);
        check("p5_fwd", 1, 1, 4'd6, 6'd6, 32'h1111, 32'h2222);
        next_cycle();
        // rs and rt waiting on the same tag
        drive(1, 0, 4'd9, 6'd9, 6'd21, 0, 32'd0, 6'd21, 0, 32'd0, 0, 6'd0, 32'd0);
        check("p5_empty2", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd21, 32'h55);
        check("p5_dual_pending", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 1, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 0, 6'd0, 32'd0);
        check("p5_dual", 1, 1, 4'd9, 6'd9, 32'h55, 32'h55);
        next_cycle();

        // Plan 6: out-of-order wakeup, issue from the middle, wakeup during shift
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 4'(k + 1), 6'(k + 1), 6'(30 + k), 0, 32'd0, 6'd0, 1, 32'(k + 1),
                  0, 6'd0, 32'd0);
            check("p6_fill", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
            next_cycle();
        end
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd32, 32'hCAFE);
        check("p6_full", 0, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();
        drive(0, 1, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd33, 32'hBEEF);
        check("p6_third", 0, 1, 4'd3, 6'd3, 32'hCAFE, 32'd3);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd30, 32'h10);
        check("p6_shift_wake", 1, 1, 4'd4, 6'd4, 32'hBEEF, 32'd4);
        next_cycle();
        drive(0, 1, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 0, 6'd0, 32'd0);
        check("p6_oldest", 1, 1, 4'd1, 6'd1, 32'h10, 32'd1);
        next_cycle();
        drive(0, 0, 4'd0, 6'd0, 6'd0, 0, 32'd0, 6'd0, 0, 32'd0, 1, 6'd31, 32'h20);
        check("p6_last", 1, 1, 4'd4, 6'd4, 32'hBEEF, 32'd4);
        next_cycle();
        idle();
        check("p6_order", 1, 1, 4'd2, 6'd2, 32'h20, 32'd2);
        next_cycle();
        reset = 1'b0;
        drive(1, 1, 4'd5, 6'd5, 6'd5, 1, 32'd5, 6'd5, 1, 32'd5, 0, 6'd0, 32'd0);
        check("p6_pre_reset", 1, 1, 4'd2, 6'd2, 32'h20, 32'd2);
        next_cycle();
        reset = 1'b1;
        idle();
        check("p6_reset", 1, 0, 4'd0, 6'd0, 32'd0, 32'd0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
